// File: rtl/pipelined_cpa_pkg.sv
// Shared types and elaboration helpers for the segmented pipelined carry-propagate adder.
// Contents: stage_ctl_t (per-stage valid/carry record), num_seg() (segment count),
// seg_width() (width of segment k; only the top segment may be narrower).
package pipelined_cpa_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int unsigned num_seg(input int unsigned width, input int unsigned seg_wd);
    return (width + seg_wd - 1) / seg_wd;
  endfunction

  function automatic int unsigned seg_width(input int unsigned k, input int unsigned width,
                                            input int unsigned seg_wd);
    if ((k == num_seg(width, seg_wd) - 1) && ((width % seg_wd) != 0)) begin
      return width % seg_wd;
    end
    return seg_wd;
  endfunction

endpackage

// File: rtl/pipelined_cpa_if.sv
// Operand/result handshake bundle for pipelined_cpa.
// Signals: in_valid/in_ready, x, y, cin (operand beat); out_valid/out_ready, sum, cout, ovf
// (result beat). With PIPELINED_CPA_SUB_EN defined, an extra sub bit travels with x/y.
// Modports: master drives operands and out_ready; slave is the adder side.
interface pipelined_cpa_if #(
  parameter int unsigned WIDTH = 25
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
`ifdef PIPELINED_CPA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef PIPELINED_CPA_SUB_EN
    output sub,
`endif
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
`ifdef PIPELINED_CPA_SUB_EN
    input  sub,
`endif
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cpa_seg.sv
// Combinational ripple-carry segment built from fulladder cells.
// Ports: i_a, i_b (Width-bit addends), i_c (carry in); o_s (sum), o_c (carry out of MSB),
// o_c_msb (carry into MSB, used for signed overflow).
module cpa_seg #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic             i_c,
  output logic [Width-1:0] o_s,
  output logic             o_c,
  output logic             o_c_msb
);

  logic [Width:0] w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    fulladder u_fa (
      .i_a  (i_a[i]),
      .i_b  (i_b[i]),
      .i_ci (w_c[i]),
      .o_s  (o_s[i]),
      .o_co (w_c[i+1])
    );
  end

  assign o_c     = w_c[Width];
  assign o_c_msb = w_c[Width-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
// Ports: i_a, i_b, i_ci (addends and carry in); o_s (sum), o_co (carry out).
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_cpa.sv
// Segmented, pipelined carry-propagate adder: sum = x + y + cin (mod 2^WIDTH), one SEG_WD-bit
// segment per stage with the carry registered between stages. Latency num_seg() cycles,
// one beat per cycle, global stall on backpressure.
// Ports: clk, rst (synchronous, active high); bus (pipelined_cpa_if.slave).
// Optional: PIPELINED_CPA_SUB_EN adds bus.sub; sub=1 computes x - y (cin ignored).
module pipelined_cpa
  import pipelined_cpa_pkg::*;
#(
  parameter int unsigned WIDTH  = 25,
  parameter int unsigned SEG_WD = 8
) (
  input logic            clk,
  input logic            rst,
  pipelined_cpa_if.slave bus
);

  localparam int unsigned NumSeg = num_seg(WIDTH, SEG_WD);

  // Index k is the input side of stage k; index k+1 is what stage k registered.
  logic [WIDTH-1:0] w_x   [NumSeg];
  logic [WIDTH-1:0] w_y   [NumSeg];
  logic [WIDTH-1:0] w_sum [NumSeg+1];
  stage_ctl_t       w_ctl [NumSeg+1];
  logic             w_adv;
  logic             r_ovf;

  assign w_adv        = !w_ctl[NumSeg].valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  assign w_x[0]         = bus.x;
  assign w_sum[0]       = '0;
  assign w_ctl[0].valid = bus.in_valid;
`ifdef PIPELINED_CPA_SUB_EN
  // Inverting y at the input keeps every stage a plain adder; the +1 rides in as carry-in.
  assign w_y[0]         = bus.sub ? ~bus.y : bus.y;
  assign w_ctl[0].carry = bus.sub | bus.cin;
`else
  assign w_y[0]         = bus.y;
  assign w_ctl[0].carry = bus.cin;
`endif

  for (genvar k = 0; k < NumSeg; k++) begin : g_stage
    localparam int unsigned Lo = k * SEG_WD;
    localparam int unsigned Sw = seg_width(k, WIDTH, SEG_WD);

    logic [Sw-1:0]    w_s;
    logic             w_co;
    logic             w_cm;
    logic [WIDTH-1:0] w_sum_n;
    logic [WIDTH-1:0] r_sum;
    stage_ctl_t       r_ctl;

    cpa_seg #(
      .Width (Sw)
    ) u_seg (
      .i_a     (w_x[k][Lo +: Sw]),
      .i_b     (w_y[k][Lo +: Sw]),
      .i_c     (w_ctl[k].carry),
      .o_s     (w_s),
      .o_c     (w_co),
      .o_c_msb (w_cm)
    );

    always_comb begin
      w_sum_n          = w_sum[k];
      w_sum_n[Lo +: Sw] = w_s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ctl <= '0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_ctl <= '{valid: w_ctl[k].valid, carry: w_co};
        r_sum <= w_sum_n;
      end
    end

    assign w_sum[k+1] = r_sum;
    assign w_ctl[k+1] = r_ctl;

    if (k < NumSeg - 1) begin : g_skew
      logic [WIDTH-1:0] r_x;
      logic [WIDTH-1:0] r_y;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_adv) begin
          r_x <= w_x[k];
          r_y <= w_y[k];
        end
      end

      assign w_x[k+1] = r_x;
      assign w_y[k+1] = r_y;
    end else begin : g_last
      // The top segment's MSB is bit WIDTH-1, so its carries give the signed overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_cm ^ w_co;
        end
      end
    end
  end

  assign bus.out_valid = w_ctl[NumSeg].valid;
  assign bus.sum       = w_sum[NumSeg];
  assign bus.cout      = w_ctl[NumSeg].carry;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_cpa.sv
// Self-checking bench for pipelined_cpa: scoreboard of expected results pushed on accept and
// popped on output consume, plus directed checks for reset, latency, stall and flush.
module tb_pipelined_cpa;

  localparam int unsigned WIDTH  = 25;
  localparam int unsigned SEG_WD = 8;
  localparam int unsigned LAT    = pipelined_cpa_pkg::num_seg(WIDTH, SEG_WD);

  logic clk;
  logic rst;
  logic mon_en;

  int n_tests;
  int n_fail;
  int n_out;

  logic [WIDTH+1:0] exp_q [$];
  logic [WIDTH+1:0] held_val;
  logic             held;

  logic [WIDTH-1:0] sx   [64];
  logic [WIDTH-1:0] sy   [64];
  logic             scin [64];
  logic             ssub [64];

  pipelined_cpa_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cpa #(
    .WIDTH  (WIDTH),
    .SEG_WD (SEG_WD)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from a plain (WIDTH+1)-bit add.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             v;
    bb = b;
    cc = c;
    if (s) begin
      bb = ~b;
      cc = 1'b1;
    end
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    v    = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    logic             s;
    if (!rst && mon_en) begin
      if (held) begin
        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check("hold_data", {bus.ovf, bus.cout, bus.sum}, held_val);
      end
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum", bus.sum, e[WIDTH-1:0]);
          check("cout", {63'd0, bus.cout}, {63'd0, e[WIDTH]});
          check("ovf", {63'd0, bus.ovf}, {63'd0, e[WIDTH+1]});
          n_out++;
        end
      end
      held     = bus.out_valid && !bus.out_ready;
      held_val = {bus.ovf, bus.cout, bus.sum};
`ifdef PIPELINED_CPA_SUB_EN
      s = bus.sub;
`else
      s = 1'b0;
`endif
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.x, bus.y, bus.cin, s));
    end else begin
      held = 1'b0;
    end
  end

  task automatic set_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input logic s);
    bus.x   = a;
    bus.y   = b;
    bus.cin = c;
`ifdef PIPELINED_CPA_SUB_EN
    bus.sub = s;
`else
    if (s) check("sub_unsupported", 64'd1, 64'd0);
`endif
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                      input logic s);
    logic ok;
    int   guard;
    guard = 0;
    ok    = 1'b0;
    set_beat(a, b, c, s);
    bus.in_valid = 1'b1;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: out_ready high; 1: out_ready low for cycles 5-9; 2: random out_ready.
  task automatic stream(input int n, input int mode);
    int i;
    int c;
    i = 0;
    c = 0;
    while (i < n && c < 1000) begin
      bus.in_valid = 1'b1;
      set_beat(sx[i], sy[i], scin[i], ssub[i]);
      case (mode)
        1:       bus.out_ready = !(c >= 5 && c <= 9);
        2:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (bus.in_ready) i++;
      @(posedge clk);
      #1;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (i < n) check("stream_timeout", 64'(i), 64'(n));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int n0;
    int cnt;
    n_tests       = 0;
    n_fail        = 0;
    n_out         = 0;
    mon_en        = 1'b0;
    held          = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_beat('0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_sum", bus.sum, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);
    check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Carry ripples through every segment; also measures latency.
    send(25'h1FFFFFF, 25'h0, 1'b1, 1'b0);
    wait_out(n);
    check("latency", 64'(n + 1), 64'(LAT));
    check("ripple_sum", bus.sum, 64'd0);
    check("ripple_cout", {63'd0, bus.cout}, 64'd1);
    check("ripple_ovf", {63'd0, bus.ovf}, 64'd0);
    drain();

    send(25'h00000FF, 25'h0000001, 1'b0, 1'b0);
    send(25'h0FFFFFF, 25'h0000001, 1'b0, 1'b0);
    send(25'h1000000, 25'h1000000, 1'b0, 1'b0);
    drain();

    // Back-to-back beats with a stall window.
    for (int i = 0; i < 8; i++) begin
      sx[i]   = WIDTH'(i);
      sy[i]   = WIDTH'(i);
      scin[i] = 1'b0;
      ssub[i] = 1'b0;
    end
    n0 = n_out;
    stream(8, 1);
    drain();
    check("bp_count", 64'(n_out - n0), 64'd8);

    // Random operands with random backpressure.
    for (int i = 0; i < 40; i++) begin
      sx[i]   = WIDTH'($urandom);
      sy[i]   = WIDTH'($urandom);
      scin[i] = 1'($urandom);
      ssub[i] = 1'b0;
`ifdef PIPELINED_CPA_SUB_EN
      ssub[i] = 1'($urandom);
`endif
    end
    n0 = n_out;
    stream(40, 2);
    drain();
    check("rand_count", 64'(n_out - n0), 64'd40);

`ifdef PIPELINED_CPA_SUB_EN
    send(25'd10, 25'd3, 1'b0, 1'b1);
    wait_out(n);
    check("sub_sum", bus.sum, 64'd7);
    check("sub_cout", {63'd0, bus.cout}, 64'd1);
    drain();
    send(25'd3, 25'd10, 1'b1, 1'b1);
    wait_out(n);
    check("sub_neg_sum", bus.sum, 64'h1FFFFF9);
    check("sub_neg_cout", {63'd0, bus.cout}, 64'd0);
    drain();
`endif

    // Reset with beats in flight: nothing stale may emerge.
    for (int i = 0; i < 3; i++) begin
      sx[i]   = WIDTH'(i + 1);
      sy[i]   = WIDTH'(3 * i + 2);
      scin[i] = 1'b0;
      ssub[i] = 1'b0;
    end
    stream(2, 0);
    bus.in_valid = 1'b1;
    set_beat(sx[2], sy[2], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("rst_flush", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    send(25'd5, 25'd7, 1'b0, 1'b0);
    wait_out(n);
    check("post_rst_latency", 64'(n + 1), 64'(LAT));
    check("post_rst_sum", bus.sum, 64'd12);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/pipelined_cpa.md
Name: pipelined_cpa

Overview:
- Parametrised, segmented, pipelined carry-propagate adder; the next-generation final-stage CPA for the multiplier datapath.
- Splits a WIDTH-bit addition into SEG_WD-bit segments, one segment per pipeline stage, and registers the carry between stages.
- Operands enter and results leave through valid/ready handshakes with full backpressure.
- Sits after the partial-product reduction tree; wider multipliers can close timing by trading latency for segment width.

Parameters:
- WIDTH, 25, operand/sum width (16+9 product width).
- SEG_WD, 8, bits added per pipeline stage; NUM_SEG = ceil(WIDTH/SEG_WD); last segment may be narrower.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  x+y+cin, modulo 2^WIDTH
- cout  output  1  unsigned carry out of bit WIDTH-1 (true MSB carry)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits cleared; out_valid=0; sum, cout, ovf=0. In-flight beats are dropped. in_ready is 1 in the cycle after reset deasserts.
- Stage k (0..NUM_SEG-1) adds segment k of x and y plus the carry registered by stage k-1. Stage 0 uses cin.
- Higher operand segments and the lower finished sum segments are carried in skew registers alongside, so one beat stays aligned across stages.
- Latency: NUM_SEG cycles from accept to out_valid with no backpressure (default 4). Throughput is one beat per cycle.
- Advance enable adv = !out_valid || out_ready. The whole pipeline shifts only when adv=1 (global stall, no bubbles collapsed). in_ready = adv.
- Accept occurs when in_valid && in_ready. Output is consumed when out_valid && out_ready.
- While out_valid=1 and out_ready=0, sum/cout/ovf are held stable and no beat is accepted or lost.
- Bubbles: a stage holding no valid beat still shifts, and its valid bit propagates as 0.
- Simultaneous accept and output consume in the same cycle is legal at full throughput.
- Boundary cases:
  - WIDTH not a multiple of SEG_WD: the top segment is WIDTH mod SEG_WD bits wide; cout and ovf are taken from bit WIDTH-1 of that segment.
  - NUM_SEG=1: purely registered single-cycle adder, latency 1.
- ovf and cout are registered together with the final sum segment.
- in_ready must not depend combinationally on in_valid. It may depend combinationally on out_ready.

Optional Feature:
- Macro: PIPELINED_CPA_SUB_EN.
- Defined:
  - Adds input port sub (1 bit, sampled with x/y on accept).
  - When sub=1, stage datapath uses ~y and forces the effective carry-in to 1, giving sum = x - y (cin is ignored).
  - cout=1 means no borrow.
  - ovf is signed subtraction overflow.
- Not defined: the port is absent; the block is add-only as above.

Decomposition:
- Package pipelined_cpa_pkg:
  - function num_seg(WIDTH,SEG_WD) returning the ceiling division;
  - function seg_width(k) returning the width of segment k;
  - typedef struct stage_ctl_t {logic valid; logic carry;} for the per-stage carry/valid record.
- One sub-module: cpa_seg, a combinational SEG_WD-bit ripple segment built from the existing fulladder cell.
  - Outputs: sum segment, carry out, carry into its MSB (for ovf).
  - Instantiated NUM_SEG times in a generate loop in pipelined_cpa.

Test Plan (defaults WIDTH=25, SEG_WD=8, latency 4):
- Carry ripple across all segments: x=25'h1FFFFFF, y=0, cin=1 -> after 4 cycles sum=0, cout=1, ovf=0.
- Segment-boundary carry: x=25'h0000FF, y=25'h000001, cin=0 -> sum=25'h000100, cout=0.
- Signed overflow: x=25'h0FFFFFF, y=1 -> sum=25'h1000000, ovf=1, cout=0. x=25'h1000000, y=25'h1000000 -> sum=0, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back beats x=i, y=i with out_ready low for cycles 5-9 -> out_valid held, in_ready=0 during stall, all 8 sums 2*i delivered in order with none dropped or duplicated.
- Reset mid-operation: accept 3 beats, assert rst at cycle 2 for 1 cycle -> out_valid stays 0 and no stale result emerges. A new beat x=5, y=7 after reset -> sum=12 after 4 cycles.
- With PIPELINED_CPA_SUB_EN: x=10, y=3, sub=1 -> sum=7, cout=1. x=3, y=10, sub=1 -> sum=25'h1FFFFF9, cout=0.
